// File: rtl/piece_position_ctrl.sv
// Key-driven X/Y origin controller: synchronised direction keys step a clamped
// position immediately on press, then auto-repeat on a shared tick after a delay.
module piece_position_ctrl #(
  parameter int WIDTH        = 10,
  parameter int X_INIT       = 192,
  parameter int Y_INIT       = 144,
  parameter int STEP         = 10,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 630,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 470,
  parameter int TICK_CYCLES  = 500000,
  parameter int REPEAT_DELAY = 6,
  parameter int REPEAT_RATE  = 2
) (
  input  logic             keyCLK,
  input  logic             resetN,
  input  logic [3:0]       key,
  input  logic             enable,
  output logic [WIDTH-1:0] startX,
  output logic [WIDTH-1:0] startY,
  output logic             moved,
  output logic [3:0]       atEdge
);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_NEG, DIR_POS} dir_t;

  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RC_W   = $clog2(RC_MAX + 1);
  localparam int TC_W   = $clog2(TICK_CYCLES);

  localparam logic [WIDTH:0]   C_STEP = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   X_LO   = (WIDTH+1)'(X_MIN);
  localparam logic [WIDTH:0]   X_HI   = (WIDTH+1)'(X_MAX);
  localparam logic [WIDTH:0]   Y_LO   = (WIDTH+1)'(Y_MIN);
  localparam logic [WIDTH:0]   Y_HI   = (WIDTH+1)'(Y_MAX);
  localparam logic [RC_W-1:0]  RC_DELAY_LAST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0]  RC_RATE_LAST  = RC_W'(REPEAT_RATE - 1);
  localparam logic [TC_W-1:0]  TC_LAST       = TC_W'(TICK_CYCLES - 1);

  // Axis index 0 is X, 1 is Y throughout.
  logic [3:0]       r_key_meta, r_key_sync;
  logic [TC_W-1:0]  r_tick_cnt;
  logic             w_tick;
  state_t           r_state   [2];
  state_t           w_state_nxt [2];
  dir_t             r_dir     [2];
  dir_t             w_dir_nxt [2];
  dir_t             w_dir_in  [2];
  logic [RC_W-1:0]  r_rc      [2];
  logic [RC_W-1:0]  w_rc_nxt  [2];
  logic [WIDTH-1:0] r_pos     [2];
  logic [WIDTH-1:0] w_pos_nxt [2];
  logic             w_step    [2];
  logic             r_moved;
  logic [3:0]       r_edge;

  // Saturating step; the extra bit catches both overflow past MAX and borrow below 0.
  function automatic logic [WIDTH-1:0] step_pos(input logic [WIDTH-1:0] pos, input dir_t d,
                                                input logic [WIDTH:0] lo, input logic [WIDTH:0] hi);
    logic [WIDTH:0] ext, sum, diff;
    ext  = {1'b0, pos};
    sum  = ext + C_STEP;
    diff = ext - C_STEP;
    step_pos = pos;
    if (d == DIR_POS)      step_pos = (sum > hi) ? hi[WIDTH-1:0] : sum[WIDTH-1:0];
    else if (d == DIR_NEG) step_pos = (diff[WIDTH] || diff < lo) ? lo[WIDTH-1:0] : diff[WIDTH-1:0];
  endfunction

  assign w_tick = (r_tick_cnt == TC_LAST);

  // X keys: 10 = left (NEG), 01 = right (POS); Y keys: 10 = down (POS), 01 = up (NEG).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_dir_in[0] = DIR_NONE;
    w_dir_in[1] = DIR_NONE;
    case (r_key_sync[3:2])
      2'b10:   w_dir_in[0] = DIR_NEG;
      2'b01:   w_dir_in[0] = DIR_POS;
      default: w_dir_in[0] = DIR_NONE;
    endcase
    case (r_key_sync[1:0])
      2'b10:   w_dir_in[1] = DIR_POS;
      2'b01:   w_dir_in[1] = DIR_NEG;
      default: w_dir_in[1] = DIR_NONE;
    endcase
  end

  always_comb begin
    for (int a = 0; a < 2; a++) begin
      w_state_nxt[a] = r_state[a];
      w_dir_nxt[a]   = r_dir[a];
      w_rc_nxt[a]    = r_rc[a];
      w_step[a]      = 1'b0;
      if (!enable || w_dir_in[a] == DIR_NONE) begin
        w_state_nxt[a] = ST_IDLE;
        w_dir_nxt[a]   = DIR_NONE;
        w_rc_nxt[a]    = '0;
      end else if (r_state[a] == ST_IDLE || w_dir_in[a] != r_dir[a]) begin
        // Fresh press or direct reversal wins over any tick in the same cycle.
        w_step[a]      = 1'b1;
        w_dir_nxt[a]   = w_dir_in[a];
        w_rc_nxt[a]    = '0;
        w_state_nxt[a] = ST_DELAY;
      end else if (w_tick) begin
        if ((r_state[a] == ST_DELAY  && r_rc[a] == RC_DELAY_LAST) ||
            (r_state[a] == ST_REPEAT && r_rc[a] == RC_RATE_LAST)) begin
          w_step[a]      = 1'b1;
          w_rc_nxt[a]    = '0;
          w_state_nxt[a] = ST_REPEAT;
        end else begin
          w_rc_nxt[a] = r_rc[a] + 1'b1;
        end
      end
      w_pos_nxt[a] = w_step[a] ? step_pos(r_pos[a], w_dir_nxt[a], (a == 0) ? X_LO : Y_LO,
                                          (a == 0) ? X_HI : Y_HI)
                               : r_pos[a];
    end
  end

  always_ff @(posedge keyCLK) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!resetN) begin
      r_key_meta <= '0;
      r_key_sync <= '0;
      r_tick_cnt <= '0;
      for (int a = 0; a < 2; a++) begin
        r_state[a] <= ST_IDLE;
        r_dir[a]   <= DIR_NONE;
        r_rc[a]    <= '0;
      end
      r_pos[0] <= WIDTH'(X_INIT);
      r_pos[1] <= WIDTH'(Y_INIT);
      r_moved  <= 1'b0;
      r_edge   <= {X_INIT == X_MAX, X_INIT == X_MIN, Y_INIT == Y_MAX, Y_INIT == Y_MIN};
    end else begin
      r_key_meta <= key;
      r_key_sync <= r_key_meta;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      for (int a = 0; a < 2; a++) begin
        r_state[a] <= w_state_nxt[a];
        r_dir[a]   <= w_dir_nxt[a];
        r_rc[a]    <= w_rc_nxt[a];
        r_pos[a]   <= w_pos_nxt[a];
      end
      r_moved <= (w_pos_nxt[0] != r_pos[0]) || (w_pos_nxt[1] != r_pos[1]);
      r_edge  <= {w_pos_nxt[0] == X_HI[WIDTH-1:0], w_pos_nxt[0] == X_LO[WIDTH-1:0],
                  w_pos_nxt[1] == Y_HI[WIDTH-1:0], w_pos_nxt[1] == Y_LO[WIDTH-1:0]};
    end
  end

  assign startX = r_pos[0];
  assign startY = r_pos[1];
  assign moved  = r_moved;
  assign atEdge = r_edge;

endmodule

// File: tb/tb_piece_position_ctrl.sv
// Directed bench for piece_position_ctrl with a 4-cycle tick, 3-tick delay, 2-tick rate.
module tb_piece_position_ctrl;

  localparam int W = 10;

  logic         keyCLK = 1'b0;
  logic         resetN = 1'b0;
  logic [3:0]   key    = 4'b0000;
  logic         enable = 1'b1;
  logic [W-1:0] startX, startY;
  logic         moved;
  logic [3:0]   atEdge;

  int checks    = 0;
  int errors    = 0;
  int moved_cnt = 0;

  piece_position_ctrl #(
    .WIDTH(W), .X_INIT(50), .Y_INIT(50), .STEP(10),
    .X_MIN(0), .X_MAX(100), .Y_MIN(0), .Y_MAX(100),
    .TICK_CYCLES(4), .REPEAT_DELAY(3), .REPEAT_RATE(2)
  ) dut (
    .keyCLK(keyCLK), .resetN(resetN), .key(key), .enable(enable),
    .startX(startX), .startY(startY), .moved(moved), .atEdge(atEdge)
  );

  always #5 keyCLK = ~keyCLK;

  // Advance n edges, stopping on the following falling edge; counts moved pulses.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge keyCLK);
      if (moved === 1'b1) moved_cnt++;
    end
  endtask

  // After return, the next rising edge is edge 1 after release; ticks land on edges 4, 8, 12, ...
  task automatic do_reset();
    resetN = 1'b0;
    cyc(3);
    resetN = 1'b1;
    moved_cnt = 0;
  endtask

  task automatic test_reset();
    key = 4'b0000; enable = 1'b1; resetN = 1'b0;
    cyc(1);
    checks++; if (startX !== 10'd50) begin errors++; $display("FAIL reset_x: got %0d want 50", startX); end
    checks++; if (startY !== 10'd50) begin errors++; $display("FAIL reset_y: got %0d want 50", startY); end
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL reset_moved: got %b want 0", moved); end
    checks++; if (atEdge !== 4'b0000) begin errors++; $display("FAIL reset_edge: got %b want 0000", atEdge); end
    do_reset();
    cyc(20);
    checks++; if (startX !== 10'd50 || startY !== 10'd50) begin
      errors++; $display("FAIL idle_pos: got %0d,%0d want 50,50", startX, startY); end
    checks++; if (moved_cnt !== 0) begin errors++; $display("FAIL idle_moved: got %0d pulses want 0", moved_cnt); end
    checks++; if (atEdge !== 4'b0000) begin errors++; $display("FAIL idle_edge: got %b want 0000", atEdge); end
  endtask

  task automatic test_tap();
    do_reset();
    key = 4'b0100;
    cyc(2);
    checks++; if (startX !== 10'd50) begin errors++; $display("FAIL tap_early: got %0d want 50", startX); end
    key = 4'b0000;
    cyc(1);
    checks++; if (startX !== 10'd60) begin errors++; $display("FAIL tap_step: got %0d want 60", startX); end
    checks++; if (moved !== 1'b1) begin errors++; $display("FAIL tap_moved: got %b want 1", moved); end
    cyc(12);
    checks++; if (startX !== 10'd60 || startY !== 10'd50) begin
      errors++; $display("FAIL tap_hold: got %0d,%0d want 60,50", startX, startY); end
    checks++; if (moved_cnt !== 1) begin errors++; $display("FAIL tap_pulses: got %0d want 1", moved_cnt); end
  endtask

  // Step edges for a press applied before edge 1: 3, then 12 (3rd tick), then every 2 ticks.
  task automatic test_hold_down();
    int steps [5] = '{3, 12, 20, 28, 36};
    int n;
    logic exp_mv;
    do_reset();
    key = 4'b0010;
    for (int k = 1; k <= 48; k++) begin
      cyc(1);
      n = 0; exp_mv = 1'b0;
      foreach (steps[j]) begin
        if (steps[j] <= k) n++;
        if (steps[j] == k) exp_mv = 1'b1;
      end
      checks++; if (startY !== W'(50 + 10 * n)) begin
        errors++; $display("FAIL down_y@%0d: got %0d want %0d", k, startY, 50 + 10 * n); end
      checks++; if (moved !== exp_mv) begin
        errors++; $display("FAIL down_moved@%0d: got %b want %b", k, moved, exp_mv); end
    end
    checks++; if (atEdge !== 4'b0010) begin errors++; $display("FAIL down_edge: got %b want 0010", atEdge); end
    checks++; if (startX !== 10'd50) begin errors++; $display("FAIL down_x: got %0d want 50", startX); end
    key = 4'b0000;
    cyc(3);
  endtask

  task automatic test_hold_left_reverse();
    int steps [5] = '{3, 12, 20, 28, 36};
    int n;
    int exp_x;
    logic exp_mv;
    do_reset();
    key = 4'b1000;
    for (int k = 1; k <= 48; k++) begin
      cyc(1);
      n = 0; exp_mv = 1'b0;
      foreach (steps[j]) begin
        if (steps[j] <= k) n++;
        if (steps[j] == k) exp_mv = 1'b1;
      end
      checks++; if (startX !== W'(50 - 10 * n)) begin
        errors++; $display("FAIL left_x@%0d: got %0d want %0d", k, startX, 50 - 10 * n); end
      checks++; if (moved !== exp_mv) begin
        errors++; $display("FAIL left_moved@%0d: got %b want %b", k, moved, exp_mv); end
    end
    checks++; if (atEdge !== 4'b0100) begin errors++; $display("FAIL left_edge: got %b want 0100", atEdge); end
    // Reversal seen by the FSM at edge 51; DELAY restarts, third tick after it is edge 60.
    key = 4'b0100;
    for (int k = 49; k <= 60; k++) begin
      cyc(1);
      exp_x  = (k < 51) ? 0 : (k < 60) ? 10 : 20;
      exp_mv = (k == 51 || k == 60);
      checks++; if (startX !== W'(exp_x)) begin
        errors++; $display("FAIL rev_x@%0d: got %0d want %0d", k, startX, exp_x); end
      checks++; if (moved !== exp_mv) begin
        errors++; $display("FAIL rev_moved@%0d: got %b want %b", k, moved, exp_mv); end
    end
    checks++; if (atEdge !== 4'b0000) begin errors++; $display("FAIL rev_edge: got %b want 0000", atEdge); end
    key = 4'b0000;
    cyc(3);
  endtask

  task automatic test_both_axes();
    do_reset();
    key = 4'b1111;
    cyc(20);
    checks++; if (startX !== 10'd50 || startY !== 10'd50) begin
      errors++; $display("FAIL both_pressed_pos: got %0d,%0d want 50,50", startX, startY); end
    checks++; if (moved_cnt !== 0) begin errors++; $display("FAIL both_pressed_moved: got %0d want 0", moved_cnt); end
    key = 4'b0110;
    cyc(2);
    checks++; if (startX !== 10'd50 || startY !== 10'd50) begin
      errors++; $display("FAIL diag_early: got %0d,%0d want 50,50", startX, startY); end
    cyc(1);
    checks++; if (startX !== 10'd60 || startY !== 10'd60) begin
      errors++; $display("FAIL diag_step: got %0d,%0d want 60,60", startX, startY); end
    checks++; if (moved !== 1'b1) begin errors++; $display("FAIL diag_moved: got %b want 1", moved); end
    key = 4'b0000;
    cyc(1);
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL diag_pulse_len: got %b want 0", moved); end
    cyc(6);
    checks++; if (moved_cnt !== 1) begin errors++; $display("FAIL diag_pulses: got %0d want 1", moved_cnt); end
  endtask

  task automatic test_enable_reset();
    do_reset();
    enable = 1'b0;
    key = 4'b0100;
    cyc(20);
    checks++; if (startX !== 10'd50 || moved_cnt !== 0) begin
      errors++; $display("FAIL dis_hold: got x=%0d pulses=%0d want 50,0", startX, moved_cnt); end
    enable = 1'b1;
    cyc(1);
    checks++; if (startX !== 10'd60 || moved !== 1'b1) begin
      errors++; $display("FAIL en_rise: got x=%0d moved=%b want 60,1", startX, moved); end
    // Press at edge 21; ticks 24, 28, 32 -> repeat at 32; now at edge 37 inside REPEAT.
    cyc(16);
    checks++; if (startX !== 10'd70 || moved_cnt !== 2) begin
      errors++; $display("FAIL en_repeat: got x=%0d pulses=%0d want 70,2", startX, moved_cnt); end
    resetN = 1'b0;
    cyc(1);
    checks++; if (startX !== 10'd50 || startY !== 10'd50 || moved !== 1'b0 || atEdge !== 4'b0000) begin
      errors++; $display("FAIL mid_reset: got x=%0d y=%0d moved=%b edge=%b want 50,50,0,0000",
                         startX, startY, moved, atEdge); end
    cyc(1);
    resetN = 1'b1;
    cyc(2);
    checks++; if (startX !== 10'd50) begin errors++; $display("FAIL post_reset_early: got %0d want 50", startX); end
    cyc(1);
    checks++; if (startX !== 10'd60) begin errors++; $display("FAIL post_reset_press: got %0d want 60", startX); end
    key = 4'b0000;
    cyc(3);
  endtask

  initial begin
    test_reset();
    test_tap();
    test_hold_down();
    test_hold_left_reverse();
    test_both_axes();
    test_enable_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
